branch_buffer_update: RTL and testbench

- Write side of the 4-entry direct-mapped branch target buffer; the fetch-stage lookup is the read side.
- Accepts resolved branch outcomes from EX and queues them in a 2-deep FIFO.
- Reads the indexed entry and decides whether to install, invalidate or drop.
- Issues single-entry writes to the buffer storage over a valid/ready write port. Also sequences a full-buffer clear on request.

---
 rtl/branch_buffer_update.sv | 126 ++++++++++++
 tb/tb_branch_buffer_update.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/branch_buffer_update.sv
// branch_buffer_update: write side of a 4-entry direct-mapped BTB with a resolution FIFO and clear sequencer.
// Optional BTB_HYSTERESIS_EN: a not-taken hit must repeat before the entry is invalidated.
module branch_buffer_update #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        resolve_valid,
   output logic        resolve_ready,
   input  logic [31:0] resolve_pc,
   input  logic        resolve_taken,
   input  logic [31:0] resolve_target,
   input  logic        clear_all,
   output logic        clear_busy,
   output logic [1:0]  lookup_ind,
   input  logic [60:0] lookup_entry,
   output logic        wen,
   input  logic        wready,
   output logic [1:0]  wind,
   output logic [60:0] wdata
);
   typedef struct packed {
      logic        bufvalid;
      logic [27:0] buftag;
      logic [31:0] buftarget;
   } buffer_t;
   typedef struct packed {
      logic [27:0] pctag;
      logic [1:0]  pcind;
      logic        taken;
      logic [31:0] target;
   } res_t;
   typedef enum logic [1:0] {IDLE, CHECK, WRITE, CLEAR} state_t;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
   res_t mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0] count;
   res_t work;
   buffer_t entry;
   state_t state;
   logic [1:0] clr_cnt;
   logic push, pop, flush, hit, do_write, strike_ok;
   logic unused_pad;
   assign unused_pad = ^resolve_pc[1:0];
   assign entry = buffer_t'(lookup_entry);
   assign resolve_ready = count != FULL && state != CLEAR;
   always_comb begin
      hit = entry.bufvalid && entry.buftag == work.pctag;
      do_write = work.taken ? !(hit && entry.buftarget == work.target) : hit && strike_ok;
      flush = clear_all && (state == CHECK || state == WRITE);
      pop = !clear_all && (state == CHECK ? !do_write : state == WRITE && wready);
      push = resolve_valid && resolve_ready;
   end
   // Abort flushes queued resolutions so nothing stale survives a clear.
   always_ff @(posedge CLK) begin
      if (!nRST || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{resolve_pc[31:4], resolve_pc[3:2], resolve_taken, resolve_target};
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= IDLE;
         work <= '0;
         lookup_ind <= '0;
         wen <= 1'b0;
         wind <= '0;
         wdata <= '0;
         clear_busy <= 1'b0;
         clr_cnt <= '0;
      end else if (clear_all && state != CLEAR) begin
         state <= CLEAR;
         wen <= 1'b0;
         wind <= '0;
         wdata <= '0;
         clear_busy <= 1'b1;
         clr_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (count != '0) begin
               work <= mem[rd_ptr];
               lookup_ind <= mem[rd_ptr].pcind;
               state <= CHECK;
            end
            CHECK: if (do_write) begin
               state <= WRITE;
               wen <= 1'b1;
               wind <= work.pcind;
               wdata <= work.taken ? {1'b1, work.pctag, work.target} : '0;
            end else state <= IDLE;
            WRITE: if (wready) begin
               wen <= 1'b0;
               state <= IDLE;
            end
            default: if (wen && wready) begin
               clr_cnt <= clr_cnt + 1'b1;
               wind <= clr_cnt + 1'b1;
               if (clr_cnt == 2'd3) begin
                  wen <= 1'b0;
                  clear_busy <= 1'b0;
                  state <= IDLE;
               end
            end else wen <= 1'b1;
         endcase
      end
   end
`ifdef BTB_HYSTERESIS_EN
   logic [3:0] strike;
   assign strike_ok = strike[work.pcind];
   always_ff @(posedge CLK) begin
      if (!nRST || (clear_all && state != CLEAR)) strike <= '0;
      else if (state == CHECK) strike[work.pcind] <= work.taken ? 1'b0 : hit ? !strike[work.pcind] : strike[work.pcind];
   end
`else
   assign strike_ok = 1'b1;
`endif
endmodule

// File: tb/tb_branch_buffer_update.sv
// tb_branch_buffer_update: directed vectors for branch_buffer_update with hand-computed expectations.
module tb_branch_buffer_update;
   logic CLK = 0, nRST = 0;
   logic resolve_valid = 0, resolve_ready, resolve_taken = 0, clear_all = 0, clear_busy;
   logic [31:0] resolve_pc = 0, resolve_target = 0;
   logic [1:0] lookup_ind, wind;
   logic [60:0] lookup_entry = 0, wdata;
   logic wen, wready = 1;
   int total = 0, bad = 0, nwr;
   logic [1:0] wi [16];
   logic [60:0] wd [16];
   logic wb [16];

   branch_buffer_update dut (
      .CLK(CLK), .nRST(nRST), .resolve_valid(resolve_valid), .resolve_ready(resolve_ready),
      .resolve_pc(resolve_pc), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
      .clear_all(clear_all), .clear_busy(clear_busy), .lookup_ind(lookup_ind),
      .lookup_entry(lookup_entry), .wen(wen), .wready(wready), .wind(wind), .wdata(wdata)
   );

   always #5 CLK = ~CLK;

   function automatic logic [60:0] bt(input logic v, input logic [27:0] t, input logic [31:0] g);
      return {v, t, g};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      resolve_valid = 1;
      resolve_pc = pc;
      resolve_taken = tk;
      resolve_target = tg;
      tick();
      resolve_valid = 0;
   endtask

   task automatic watch(input int n);
      nwr = 0;
      for (int i = 0; i < n; i++) begin
         if (wen && wready && nwr < 16) begin
            wi[nwr] = wind;
            wd[nwr] = wdata;
            wb[nwr] = clear_busy;
            nwr++;
         end
         tick();
      end
   endtask

   initial begin
      tick();
      tick();
      chk("rst_wen", wen, 0);
      chk("rst_wind", wind, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_lookup", lookup_ind, 0);
      chk("rst_busy", clear_busy, 0);
      chk("rst_ready", resolve_ready, 1);
      nRST = 1;
      // install: taken, empty entry
      send(32'h48, 1, 32'h100);
      chk("t1_wen_n1", wen, 0);
      tick();
      chk("t1_lookup", lookup_ind, 2);
      chk("t1_wen_n2", wen, 0);
      tick();
      chk("t1_wen_n3", wen, 1);
      chk("t1_wind", wind, 2);
      chk("t1_wdata", wdata, bt(1, 28'h4, 32'h100));
      watch(5);
      chk("t1_once", nwr, 1);
      // redundant hit, pad bits set
      lookup_entry = bt(1, 28'h4, 32'h100);
      send(32'h4B, 1, 32'h100);
      watch(6);
      chk("t2_nowr", nwr, 0);
      chk("t2_lookup", lookup_ind, 2);
      chk("t2_ready", resolve_ready, 1);
      // not-taken hit
`ifdef BTB_HYSTERESIS_EN
      send(32'h48, 0, 32'h0);
      watch(6);
      chk("t3_strike_nowr", nwr, 0);
`endif
      send(32'h48, 0, 32'h0);
      watch(6);
      chk("t3_inv_n", nwr, 1);
      chk("t3_inv_wind", wi[0], 2);
      chk("t3_inv_wdata", wd[0], 0);
      // backpressure
      lookup_entry = 0;
      wready = 0;
      resolve_valid = 1;
      resolve_taken = 1;
      resolve_pc = 32'h14;
      resolve_target = 32'h200;
      tick();
      chk("t4_ready1", resolve_ready, 1);
      resolve_pc = 32'h28;
      resolve_target = 32'h300;
      tick();
      chk("t4_full", resolve_ready, 0);
      resolve_pc = 32'h3C;
      resolve_target = 32'h400;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("t4_wen_hold", wen, 1);
         chk("t4_wind_hold", wind, 1);
         chk("t4_wdata_hold", wdata, bt(1, 28'h1, 32'h200));
         chk("t4_full_hold", resolve_ready, 0);
         tick();
      end
      resolve_valid = 0;
      wready = 1;
      watch(8);
      chk("t4_n", nwr, 2);
      chk("t4_w0_ind", wi[0], 1);
      chk("t4_w0_data", wd[0], bt(1, 28'h1, 32'h200));
      chk("t4_w1_ind", wi[1], 2);
      chk("t4_w1_data", wd[1], bt(1, 28'h2, 32'h300));
      // clear during a stalled write
      wready = 0;
      send(32'h14, 1, 32'h500);
      send(32'h28, 1, 32'h600);
      tick();
      chk("t5_wen_pre", wen, 1);
      chk("t5_wind_pre", wind, 1);
      clear_all = 1;
      tick();
      clear_all = 0;
      chk("t5_wen_drop", wen, 0);
      chk("t5_busy", clear_busy, 1);
      chk("t5_ready0", resolve_ready, 0);
      wready = 1;
      watch(14);
      chk("t5_n", nwr, 4);
      for (int k = 0; k < 4; k++) begin
         chk("t5_clr_ind", wi[k], k[1:0]);
         chk("t5_clr_data", wd[k], 0);
         chk("t5_clr_busy", wb[k], 1);
      end
      chk("t5_busy_end", clear_busy, 0);
      chk("t5_ready_end", resolve_ready, 1);
      // reset mid-clear
      clear_all = 1;
      tick();
      clear_all = 0;
      tick();
      tick();
      tick();
      chk("t6_cnt2", wind, 2);
      chk("t6_busy", clear_busy, 1);
      chk("t6_lookup_pre", lookup_ind, 1);
      nRST = 0;
      tick();
      nRST = 1;
      chk("t6_wen", wen, 0);
      chk("t6_wind", wind, 0);
      chk("t6_wdata", wdata, 0);
      chk("t6_lookup", lookup_ind, 0);
      chk("t6_busy_rst", clear_busy, 0);
      chk("t6_ready", resolve_ready, 1);
      watch(6);
      chk("t6_nowr", nwr, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
